// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
//
// Shares the single data-cache port between the LSU load path and the
// store-queue retire path. One request wins per cycle (Arbitrate), is
// registered onto the cache port (Issue), and its answer is registered back
// to the owner (Response). A store that misses while the miss-status queue
// is full is turned into a retry so the SQ re-presents it.
//
// Optional feature macro: DC_ARB_STARVE_EN
//   defined   : a saturating starvation counter forces a store grant after
//               STARVE_LIMIT consecutive denied store cycles.
//   undefined : strict load priority; a store wins only with no eligible load.
//
// Ports
//   clk, n_rst            clock (rising edge), async active-low reset
//   i_flush               kills load in Issue, blocks load grant this cycle
//   i_ld_req/i_ld_addr    load request          -> o_ld_ack (combinational)
//   o_ld_resp_*           registered load response (valid/hit/data)
//   i_st_req/addr/data/byte_en  retiring store  -> o_st_ack (combinational)
//   o_st_done/o_st_retry  registered store completion / retry pulse
//   o_dc_*                registered cache request
//   i_dc_hit/i_dc_rdata/i_dc_msq_full   combinational cache answer in Issue

module dcache_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    i_flush,
    input  logic                    i_ld_req,
    input  logic [ADDR_WIDTH-1:0]   i_ld_addr,
    output logic                    o_ld_ack,
    output logic                    o_ld_resp_valid,
    output logic                    o_ld_resp_hit,
    output logic [DATA_WIDTH-1:0]   o_ld_resp_data,
    input  logic                    i_st_req,
    input  logic [ADDR_WIDTH-1:0]   i_st_addr,
    input  logic [DATA_WIDTH-1:0]   i_st_data,
    input  logic [DATA_WIDTH/8-1:0] i_st_byte_en,
    output logic                    o_st_ack,
    output logic                    o_st_done,
    output logic                    o_st_retry,
    output logic                    o_dc_re,
    output logic                    o_dc_we,
    output logic [ADDR_WIDTH-1:0]   o_dc_addr,
    output logic [DATA_WIDTH-1:0]   o_dc_wdata,
    output logic [DATA_WIDTH/8-1:0] o_dc_byte_en,
    input  logic                    i_dc_hit,
    input  logic [DATA_WIDTH-1:0]   i_dc_rdata,
    input  logic                    i_dc_msq_full
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic ld_elig;
    logic st_elig;
    logic ld_grant;
    logic st_grant;
    logic force_st;

    // Issue stage registers
    logic                  dc_re_q,      dc_re_d;
    logic                  dc_we_q,      dc_we_d;
    logic [ADDR_WIDTH-1:0] dc_addr_q,    dc_addr_d;
    logic [DATA_WIDTH-1:0] dc_wdata_q,   dc_wdata_d;
    logic [BE_WIDTH-1:0]   dc_byte_en_q, dc_byte_en_d;

    // Response stage registers
    logic                  ld_resp_valid_q, ld_resp_valid_d;
    logic                  ld_resp_hit_q,   ld_resp_hit_d;
    logic [DATA_WIDTH-1:0] ld_resp_data_q,  ld_resp_data_d;
    logic                  st_done_q,       st_done_d;
    logic                  st_retry_q,      st_retry_d;

    // One store in flight from ack until it leaves Response
    logic                  st_busy_q,       st_busy_d;

    assign ld_elig = i_ld_req && !i_flush;
    assign st_elig = i_st_req && !st_busy_q;

    // Load wins by default; the store wins when alone or when starved.
    assign st_grant = st_elig && (!ld_elig || force_st);
    assign ld_grant = ld_elig && !st_grant;

    assign o_ld_ack = ld_grant;
    assign o_st_ack = st_grant;

`ifdef DC_ARB_STARVE_EN
    localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;

    // Counts cycles the store was eligible yet lost to a load; saturates at
    // the limit, where it forces the next store grant.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (st_grant) begin
            starve_cnt_d = '0;
        end else if (st_elig && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign force_st = (starve_cnt_q == STARVE_MAX);
`else
    assign force_st = 1'b0;
`endif

    // Next-state for the Issue and Response stages. Address/data of the
    // issue register hold when nothing is granted; only the enables drop.
    // Load hit/data are captured whenever a load is in Issue.
    always_comb begin
        dc_re_d         = ld_grant;
        dc_we_d         = st_grant;
        dc_addr_d       = dc_addr_q;
        dc_wdata_d      = dc_wdata_q;
        dc_byte_en_d    = dc_byte_en_q;
        ld_resp_valid_d = dc_re_q && !i_flush;
        ld_resp_hit_d   = ld_resp_hit_q;
        ld_resp_data_d  = ld_resp_data_q;
        st_done_d       = dc_we_q && (i_dc_hit || !i_dc_msq_full);
        st_retry_d      = dc_we_q && !i_dc_hit && i_dc_msq_full;
        st_busy_d       = st_busy_q;

        if (ld_grant) begin
            dc_addr_d = i_ld_addr;
        end else if (st_grant) begin
            dc_addr_d    = i_st_addr;
            dc_wdata_d   = i_st_data;
            dc_byte_en_d = i_st_byte_en;
        end

        if (dc_re_q) begin
            ld_resp_hit_d  = i_dc_hit;
            ld_resp_data_d = i_dc_rdata;
        end

        // The store leaves Response in the cycle its done/retry is high.
        if (st_grant) begin
            st_busy_d = 1'b1;
        end else if (st_done_q || st_retry_q) begin
            st_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dc_re_q         <= 1'b0;
            dc_we_q         <= 1'b0;
            dc_addr_q       <= '0;
            dc_wdata_q      <= '0;
            dc_byte_en_q    <= '0;
            ld_resp_valid_q <= 1'b0;
            ld_resp_hit_q   <= 1'b0;
            ld_resp_data_q  <= '0;
            st_done_q       <= 1'b0;
            st_retry_q      <= 1'b0;
            st_busy_q       <= 1'b0;
        end else begin
            dc_re_q         <= dc_re_d;
            dc_we_q         <= dc_we_d;
            dc_addr_q       <= dc_addr_d;
            dc_wdata_q      <= dc_wdata_d;
            dc_byte_en_q    <= dc_byte_en_d;
            ld_resp_valid_q <= ld_resp_valid_d;
            ld_resp_hit_q   <= ld_resp_hit_d;
            ld_resp_data_q  <= ld_resp_data_d;
            st_done_q       <= st_done_d;
            st_retry_q      <= st_retry_d;
            st_busy_q       <= st_busy_d;
        end
    end

    assign o_dc_re         = dc_re_q;
    assign o_dc_we         = dc_we_q;
    assign o_dc_addr       = dc_addr_q;
    assign o_dc_wdata      = dc_wdata_q;
    assign o_dc_byte_en    = dc_byte_en_q;
    assign o_ld_resp_valid = ld_resp_valid_q;
    assign o_ld_resp_hit   = ld_resp_hit_q;
    assign o_ld_resp_data  = ld_resp_data_q;
    assign o_st_done       = st_done_q;
    assign o_st_retry      = st_retry_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter
//
// Self-checking bench for dcache_port_arbiter. Expected load and store
// responses are pushed to queues when the request is driven and popped by a
// monitor when the design reports a response. A small cache model answers
// the Issue stage combinationally from o_dc_addr.

module tb_dcache_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;

    typedef struct packed {
        logic          hit;
        logic [DW-1:0] data;
    } ld_exp_t;

    logic          clk;
    logic          n_rst;
    logic          i_flush;
    logic          i_ld_req;
    logic [AW-1:0] i_ld_addr;
    logic          o_ld_ack;
    logic          o_ld_resp_valid;
    logic          o_ld_resp_hit;
    logic [DW-1:0] o_ld_resp_data;
    logic          i_st_req;
    logic [AW-1:0] i_st_addr;
    logic [DW-1:0] i_st_data;
    logic [BW-1:0] i_st_byte_en;
    logic          o_st_ack;
    logic          o_st_done;
    logic          o_st_retry;
    logic          o_dc_re;
    logic          o_dc_we;
    logic [AW-1:0] o_dc_addr;
    logic [DW-1:0] o_dc_wdata;
    logic [BW-1:0] o_dc_byte_en;
    logic          i_dc_hit;
    logic [DW-1:0] i_dc_rdata;
    logic          i_dc_msq_full;

    logic tb_hit;
    logic tb_msq_full;

    int checks = 0;
    int errors = 0;

    ld_exp_t ld_q[$];
    logic    st_q[$];

    dcache_port_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_flush        (i_flush),
        .i_ld_req       (i_ld_req),
        .i_ld_addr      (i_ld_addr),
        .o_ld_ack       (o_ld_ack),
        .o_ld_resp_valid(o_ld_resp_valid),
        .o_ld_resp_hit  (o_ld_resp_hit),
        .o_ld_resp_data (o_ld_resp_data),
        .i_st_req       (i_st_req),
        .i_st_addr      (i_st_addr),
        .i_st_data      (i_st_data),
        .i_st_byte_en   (i_st_byte_en),
        .o_st_ack       (o_st_ack),
        .o_st_done      (o_st_done),
        .o_st_retry     (o_st_retry),
        .o_dc_re        (o_dc_re),
        .o_dc_we        (o_dc_we),
        .o_dc_addr      (o_dc_addr),
        .o_dc_wdata     (o_dc_wdata),
        .o_dc_byte_en   (o_dc_byte_en),
        .i_dc_hit       (i_dc_hit),
        .i_dc_rdata     (i_dc_rdata),
        .i_dc_msq_full  (i_dc_msq_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache contents: 0x100 holds 0xDEADBEEF, other words are address-derived.
    function automatic logic [DW-1:0] cache_data(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign i_dc_rdata    = cache_data(o_dc_addr);
    assign i_dc_hit      = tb_hit;
    assign i_dc_msq_full = tb_msq_full;

    // Response monitor: every response must match the oldest expectation.
    always @(negedge clk) begin
        if (n_rst) begin
            if (o_ld_resp_valid) begin
                checks++;
                if (ld_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL ld_resp_unexpected: got valid=1 required no response");
                end else begin
                    ld_exp_t e;
                    e = ld_q.pop_front();
                    if ({o_ld_resp_hit, o_ld_resp_data} !== {e.hit, e.data}) begin
                        errors++;
                        $display("[TB] FAIL ld_resp: got hit=%0b data=%h required hit=%0b data=%h",
                                 o_ld_resp_hit, o_ld_resp_data, e.hit, e.data);
                    end
                end
            end
            if (o_st_done || o_st_retry) begin
                checks++;
                if (st_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL st_resp_unexpected: got done=%0b retry=%0b required none",
                             o_st_done, o_st_retry);
                end else begin
                    logic exp_done;
                    exp_done = st_q.pop_front();
                    if ({o_st_done, o_st_retry} !== {exp_done, !exp_done}) begin
                        errors++;
                        $display("[TB] FAIL st_resp: got done=%0b retry=%0b required done=%0b retry=%0b",
                                 o_st_done, o_st_retry, exp_done, !exp_done);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_flush  = 1'b0;
        i_ld_req = 1'b0;
        i_st_req = 1'b0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (ld_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drained: got %0d ld / %0d st pending required 0 / 0",
                     name, ld_q.size(), st_q.size());
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        idle_inputs();
        i_ld_addr    = '0;
        i_st_addr    = '0;
        i_st_data    = '0;
        i_st_byte_en = '0;
        tb_hit       = 1'b1;
        tb_msq_full  = 1'b0;
        #2;
        checks++;
        if ({o_ld_ack, o_ld_resp_valid, o_ld_resp_hit, o_ld_resp_data, o_st_ack,
             o_st_done, o_st_retry, o_dc_re, o_dc_we, o_dc_addr, o_dc_wdata,
             o_dc_byte_en} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got nonzero outputs (dc_re=%0b dc_we=%0b addr=%h) required all 0",
                     o_dc_re, o_dc_we, o_dc_addr);
        end
        tick();
        tick();
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_single_load();
        i_ld_req  = 1'b1;
        i_ld_addr = 32'h100;
        #1;
        checks++;
        if ({o_ld_ack, o_st_ack} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL single_ld_ack: got ld=%0b st=%0b required ld=1 st=0", o_ld_ack, o_st_ack);
        end
        ld_q.push_back('{hit: 1'b1, data: 32'hDEADBEEF});
        tick();
        i_ld_req = 1'b0;
        tb_hit   = 1'b1;
        #1;
        checks++;
        if ({o_dc_re, o_dc_we, o_dc_addr} !== {1'b1, 1'b0, 32'h100}) begin
            errors++;
            $display("[TB] FAIL single_ld_issue: got re=%0b we=%0b addr=%h required re=1 we=0 addr=100",
                     o_dc_re, o_dc_we, o_dc_addr);
        end
        tick();
        checks++;
        if (o_ld_resp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_ld_resp_valid: got %0b required 1", o_ld_resp_valid);
        end
        tick();
        tick();
        check_drained("single_load");
    endtask

    task automatic test_store_hit();
        i_st_req     = 1'b1;
        i_st_addr    = 32'h200;
        i_st_data    = 32'h12345678;
        i_st_byte_en = 4'hF;
        #1;
        checks++;
        if ({o_st_ack, o_ld_ack} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL st_hit_ack: got st=%0b ld=%0b required st=1 ld=0", o_st_ack, o_ld_ack);
        end
        st_q.push_back(1'b1);
        tick();
        tb_hit = 1'b1;
        #1;
        checks++;
        if ({o_dc_we, o_dc_re, o_dc_addr, o_dc_wdata, o_dc_byte_en} !==
            {1'b1, 1'b0, 32'h200, 32'h12345678, 4'hF}) begin
            errors++;
            $display("[TB] FAIL st_hit_issue: got we=%0b re=%0b addr=%h wdata=%h be=%h required we=1 re=0 addr=200 wdata=12345678 be=f",
                     o_dc_we, o_dc_re, o_dc_addr, o_dc_wdata, o_dc_byte_en);
        end
        checks++;
        if (o_st_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL st_busy_n1: got ack=%0b required 0", o_st_ack);
        end
        tick();
        checks++;
        if ({o_st_ack, o_st_done} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL st_busy_n2: got ack=%0b done=%0b required ack=0 done=1", o_st_ack, o_st_done);
        end
        tick();
        checks++;
        if (o_st_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL st_reack_n3: got ack=%0b required 1", o_st_ack);
        end
        st_q.push_back(1'b1);
        tick();
        i_st_req = 1'b0;
        tick();
        tick();
        tick();
        check_drained("store_hit");
    endtask

    task automatic test_store_retry();
        i_st_req     = 1'b1;
        i_st_addr    = 32'h300;
        i_st_data    = 32'hA5A55A5A;
        i_st_byte_en = 4'h3;
        #1;
        checks++;
        if (o_st_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL retry_ack: got %0b required 1", o_st_ack);
        end
        st_q.push_back(1'b0);
        tick();
        tb_hit      = 1'b0;
        tb_msq_full = 1'b1;
        tick();
        tb_msq_full = 1'b0;
        #1;
        checks++;
        if ({o_st_retry, o_st_done} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL retry_pulse: got retry=%0b done=%0b required retry=1 done=0", o_st_retry, o_st_done);
        end
        tick();
        checks++;
        if (o_st_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL retry_reack: got %0b required 1", o_st_ack);
        end
        st_q.push_back(1'b1);
        tick();
        i_st_req = 1'b0;
        tick();
        tick();
        tick();
        tb_hit = 1'b1;
        check_drained("store_retry");
    endtask

    task automatic test_starvation();
        logic st_taken;
        logic exp_st;
        st_taken = 1'b0;
        i_st_addr    = 32'h440;
        i_st_data    = 32'h0BADF00D;
        i_st_byte_en = 4'hC;
        for (int i = 0; i < 6; i++) begin
            i_ld_req  = 1'b1;
            i_ld_addr = 32'h400 + 32'(4 * i);
            i_st_req  = !st_taken;
`ifdef DC_ARB_STARVE_EN
            exp_st = (i == 4);
`else
            exp_st = 1'b0;
`endif
            #1;
            checks++;
            if ({o_st_ack, o_ld_ack} !== {exp_st, !exp_st}) begin
                errors++;
                $display("[TB] FAIL starve_cycle%0d: got st=%0b ld=%0b required st=%0b ld=%0b",
                         i, o_st_ack, o_ld_ack, exp_st, !exp_st);
            end
            if (exp_st) begin
                st_q.push_back(1'b1);
                st_taken = 1'b1;
            end else begin
                ld_q.push_back('{hit: 1'b1, data: cache_data(i_ld_addr)});
            end
            tick();
        end
        i_ld_req = 1'b0;
        i_st_req = !st_taken;
        #1;
        checks++;
        if (o_st_ack !== !st_taken) begin
            errors++;
            $display("[TB] FAIL starve_store_alone: got ack=%0b required %0b", o_st_ack, !st_taken);
        end
        if (!st_taken) st_q.push_back(1'b1);
        tick();
        i_st_req = 1'b0;
        tick();
        tick();
        tick();
        check_drained("starvation");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            i_ld_req  = 1'b1;
            i_ld_addr = 32'h900 + 32'(4 * i);
            #1;
            checks++;
            if (o_ld_ack !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_ack%0d: got %0b required 1", i, o_ld_ack);
            end
            if (i > 0) begin
                checks++;
                if ({o_dc_re, o_dc_addr} !== {1'b1, 32'h900 + 32'(4 * (i - 1))}) begin
                    errors++;
                    $display("[TB] FAIL b2b_issue%0d: got re=%0b addr=%h required re=1 addr=%h",
                             i, o_dc_re, o_dc_addr, 32'h900 + 32'(4 * (i - 1)));
                end
            end
            ld_q.push_back('{hit: 1'b1, data: cache_data(i_ld_addr)});
            tick();
        end
        i_ld_req = 1'b0;
        tick();
        tick();
        tick();
        check_drained("back_to_back");
    endtask

    task automatic test_flush();
        i_st_req     = 1'b1;
        i_st_addr    = 32'h600;
        i_st_data    = 32'hCAFEF00D;
        i_st_byte_en = 4'h3;
        #1;
        checks++;
        if (o_st_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_st_ack: got %0b required 1", o_st_ack);
        end
        st_q.push_back(1'b1);
        tick();
        i_st_req  = 1'b0;
        i_ld_req  = 1'b1;
        i_ld_addr = 32'h500;
        #1;
        checks++;
        if (o_ld_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_ld_ack: got %0b required 1", o_ld_ack);
        end
        tick();
        i_ld_addr = 32'h504;
        i_flush   = 1'b1;
        #1;
        checks++;
        if ({o_ld_ack, o_dc_re, o_st_done} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL flush_cycle: got ack=%0b dc_re=%0b st_done=%0b required ack=0 dc_re=1 st_done=1",
                     o_ld_ack, o_dc_re, o_st_done);
        end
        tick();
        i_flush  = 1'b0;
        i_ld_req = 1'b0;
        #1;
        checks++;
        if (o_ld_resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_killed: got valid=%0b required 0", o_ld_resp_valid);
        end
        tick();
        i_ld_req  = 1'b1;
        i_ld_addr = 32'h700;
        ld_q.push_back('{hit: 1'b1, data: cache_data(32'h700)});
        tick();
        i_ld_req = 1'b0;
        tick();
        i_flush = 1'b1;
        #1;
        checks++;
        if (o_ld_resp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_late: got valid=%0b required 1", o_ld_resp_valid);
        end
        tick();
        i_flush = 1'b0;
        tick();
        tick();
        check_drained("flush");
    endtask

    task automatic test_reset_midop();
        i_ld_req  = 1'b1;
        i_ld_addr = 32'h800;
        tick();
        i_ld_req = 1'b0;
        #1;
        checks++;
        if (o_dc_re !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midop_issue: got dc_re=%0b required 1", o_dc_re);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({o_ld_ack, o_ld_resp_valid, o_ld_resp_hit, o_ld_resp_data, o_st_ack,
             o_st_done, o_st_retry, o_dc_re, o_dc_we, o_dc_addr, o_dc_wdata,
             o_dc_byte_en} !== '0) begin
            errors++;
            $display("[TB] FAIL midop_reset: got dc_re=%0b addr=%h resp_valid=%0b required all 0",
                     o_dc_re, o_dc_addr, o_ld_resp_valid);
        end
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        tick();
        tick();
        check_drained("reset_midop");
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_store_hit();
        test_store_retry();
        test_starvation();
        test_back_to_back();
        test_flush();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Shares the single data-cache port between the LSU load path and the store-queue retire path. Registers one winning request per cycle onto the cache port and returns a registered response to its owner. Converts a store miss with a full miss-status queue (MSQ) into a retry. Sits between the LSU/SQ and the data cache, replacing the separate load and retire cache interfaces.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- STARVE_LIMIT, 4, consecutive denied store-request cycles before the store is forced to win (range 1..15)

Ports:
- clk  in  1  clock; all logic on rising edge
- n_rst  in  1  asynchronous active-low reset
- i_flush  in  1  pipeline flush: kills in-flight load responses and blocks load grant this cycle
- i_ld_req  in  1  load request valid
- i_ld_addr  in  ADDR_WIDTH  load address
- o_ld_ack  out  1  combinational; load accepted this cycle
- o_ld_resp_valid  out  1  load response valid
- o_ld_resp_hit  out  1  load hit
- o_ld_resp_data  out  DATA_WIDTH  load data
- i_st_req  in  1  retiring store valid
- i_st_addr  in  ADDR_WIDTH  store address
- i_st_data  in  DATA_WIDTH  store data
- i_st_byte_en  in  DATA_WIDTH/8  store byte enables
- o_st_ack  out  1  combinational; store accepted this cycle
- o_st_done  out  1  store completed: hit, or miss handed to MSQ
- o_st_retry  out  1  miss with MSQ full; SQ re-presents the same store
- o_dc_re  out  1  cache read enable
- o_dc_we  out  1  cache write enable
- o_dc_addr  out  ADDR_WIDTH  cache address
- o_dc_wdata  out  DATA_WIDTH  cache write data
- o_dc_byte_en  out  DATA_WIDTH/8  cache byte enables
- i_dc_hit  in  1  cache hit, same cycle as the request
- i_dc_rdata  in  DATA_WIDTH  cache read data
- i_dc_msq_full  in  1  MSQ cannot accept a miss this cycle

## Operation
- Pipeline stages:
  - Arbitrate (A): combinational grant; the winner is acked.
  - Issue (I): registered o_dc_* outputs drive the cache; the cache answers combinationally.
  - Response (R): registered response outputs.
- Store eligibility: st_busy is set on store ack and cleared when the store leaves R. st_busy blocks store grant, so at most one store is in flight and acks are at least 3 cycles apart.
- Load eligibility: i_ld_req && !i_flush.
- Store eligibility: i_st_req && !st_busy.
- Grant rules:
  - Load wins by default.
  - Store wins when it is the only eligible requester, or when starve_cnt == STARVE_LIMIT.
  - At most one ack per cycle.
- starve_cnt: saturating, $clog2(STARVE_LIMIT+1) bits.
  - Increments when the store is eligible but not granted.
  - Clears on store grant.
  - Holds otherwise.
- Issue register for a load: o_dc_re=1, o_dc_we=0, o_dc_addr=i_ld_addr.
- Issue register for a store: o_dc_we=1, o_dc_re=0, addr/wdata/byte_en from the store.
- No grant: o_dc_re=o_dc_we=0; addr/data hold their previous values.
- Load response: o_ld_resp_valid = issued load && !i_flush (sampled in I). hit/data are captured from i_dc_hit/i_dc_rdata.
- Store response:
  - o_st_done = i_dc_hit || !i_dc_msq_full.
  - o_st_retry = !i_dc_hit && i_dc_msq_full.
  - Exactly one of the two pulses for 1 cycle per acked store.
- i_flush never affects stores, which are already committed.
- Reset (async): all outputs 0, st_busy=0, starve_cnt=0. Reset mid-operation discards in-flight requests with no response.

## Timing
- Ack in cycle N → o_dc_* valid in N+1 → response in N+2. Load-to-response latency is 2 cycles.
- Loads are fully pipelined, one per cycle.
- Earliest next store ack is N+3. The SQ keeps presenting the same store through N+2 and advances its head only after o_st_done.
- A flush in N+1 kills a load acked in N. A flush in N+2 does not retract a response already valid in N+2.
- Load and store requesting together with starve_cnt < STARVE_LIMIT: load acked, counter increments.

## Configuration
- DC_ARB_STARVE_EN defined: the starvation counter and forced store grant are present, as described above.
- DC_ARB_STARVE_EN undefined: strict load priority. No counter exists; a store is granted only in cycles with no eligible load.

## Test plan
- Single load to 0x100, cache hit with rdata 0xDEADBEEF → o_ld_ack at N, o_dc_re/o_dc_addr=0x100 at N+1, o_ld_resp_valid/hit/data=0xDEADBEEF at N+2.
- Store to 0x200, data 0x12345678, byte_en 0xF, hit → o_dc_we at N+1, o_st_done at N+2. Store held requesting → next o_st_ack no earlier than N+3.
- Store miss with i_dc_msq_full=1 → o_st_retry at N+2, no o_st_done. Re-presented store with MSQ not full → o_st_done.
- Continuous loads every cycle plus a pending store, STARVE_LIMIT=4 → store acked on the 5th cycle. With DC_ARB_STARVE_EN undefined → store never acked while loads persist.
- Load acked at N, i_flush at N+1 → no o_ld_resp_valid at N+2. Concurrent store response still reported.
- n_rst asserted with a load in I → all outputs 0 immediately. No response after reset release.
